// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported, multi-cycle data memory.
// Define DM_ARB_FIXED_PRIO_EN to make port 1 always win ties instead of alternating.
//
// state | meaning
// IDLE  | waiting for a request, grant decided on the next edge
// BUSY  | command latched and held on mem_*, waiting for mem_ack_i
// RESP  | one-cycle ack to the granted port, memory enable low
module dm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              ack0_o,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q;
  logic              grant_id_q;
  logic              win;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
`ifndef DM_ARB_FIXED_PRIO_EN
  logic              last_grant_q;
`endif

  always_comb begin
`ifdef DM_ARB_FIXED_PRIO_EN
    win = req1_i;
`else
    win = (req0_i && req1_i) ? ~last_grant_q : req1_i;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_id_q   <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
`ifndef DM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_i || req1_i) begin
            grant_id_q   <= win;
            mem_enable_o <= 1'b1;
            mem_write_o  <= win ? we1_i : we0_i;
            mem_addr_o   <= win ? addr1_i : addr0_i;
            mem_data_o   <= win ? wdata1_i : wdata0_i;
            state_q      <= BUSY;
`ifndef DM_ARB_FIXED_PRIO_EN
            last_grant_q <= win;
`endif
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            state_q      <= RESP;
          end
        end
        RESP: begin
          // Read data is shown combinationally this cycle and held from here on.
          if (!mem_write_o) begin
            if (grant_id_q) rdata1_q <= mem_data_i;
            else            rdata0_q <= mem_data_i;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0_o   = (state_q == RESP) && !grant_id_q;
  assign ack1_o   = (state_q == RESP) &&  grant_id_q;
  assign rdata0_o = (ack0_o && !mem_write_o) ? mem_data_i : rdata0_q;
  assign rdata1_o = (ack1_o && !mem_write_o) ? mem_data_i : rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized two-port traffic
// checked against a transaction-level model with a behavioural memory.
module tb_dm_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 256;
  localparam int L_BUSY = 9;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              req0_i = 1'b0, we0_i = 1'b0;
  logic [ADDR_W-1:0] addr0_i = '0;
  logic [DATA_W-1:0] wdata0_i = '0;
  logic              req1_i = 1'b0, we1_i = 1'b0;
  logic [ADDR_W-1:0] addr1_i = '0;
  logic [DATA_W-1:0] wdata1_i = '0;
  logic              ack0_o, ack1_o;
  logic [DATA_W-1:0] rdata0_o, rdata1_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i = 1'b0;
  logic [DATA_W-1:0] mem_data_i = '0;

  int checks = 0;
  int failures = 0;
  int dut_log[$];

  logic [DATA_W-1:0] mem_store [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ref_store [logic [ADDR_W-1:0]];

  always #5 clk_i = ~clk_i;

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
    .ack0_o(ack0_o), .rdata0_o(rdata0_o),
    .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
    .ack1_o(ack1_o), .rdata1_o(rdata1_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
  );

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'hC3C3_0000}};
  endfunction

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_word(a);
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_store.exists(a) ? ref_store[a] : init_word(a);
  endfunction

  // Memory: acks in its 9th enabled cycle, samples the command then, returns data the cycle after.
  int                busy_cnt = 0;
  logic              lat_we = 1'b0;
  logic [ADDR_W-1:0] lat_addr = '0;
  always @(posedge clk_i) begin
    #1;
    if (mem_ack_i && !lat_we) mem_data_i = mem_rd(lat_addr);
    else                      mem_data_i = {8{$urandom}};
    busy_cnt  = mem_enable_o ? busy_cnt + 1 : 0;
    mem_ack_i = (busy_cnt == L_BUSY);
    if (mem_ack_i) begin
      lat_we   = mem_write_o;
      lat_addr = mem_addr_o;
      if (mem_write_o) mem_store[mem_addr_o] = mem_data_o;
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    req0_i = 1'b0; we0_i = 1'b0; addr0_i = '0; wdata0_i = '0;
    req1_i = 1'b0; we1_i = 1'b0; addr1_i = '0; wdata1_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Drives one transaction on port p and reports what was observed; callers judge it.
  task automatic run_txn(input int p, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, output logic got,
                         output logic [DATA_W-1:0] rd, output int lat, output int en_cnt,
                         output logic resp_en, output logic other_ack, output logic bad_cmd);
    int n;
    got = 1'b0; rd = '0; lat = 0; en_cnt = 0; resp_en = 1'b0; other_ack = 1'b0; bad_cmd = 1'b0;
    n = 0;
    @(negedge clk_i);
    if (p == 0) begin req0_i = 1'b1; we0_i = we; addr0_i = a; wdata0_i = wd; end
    else        begin req1_i = 1'b1; we1_i = we; addr1_i = a; wdata1_i = wd; end
    while (!got && n < 40) begin
      @(negedge clk_i);
      n++;
      if (mem_enable_o) begin
        en_cnt++;
        if (mem_addr_o !== a || mem_write_o !== we || (we && mem_data_o !== wd)) bad_cmd = 1'b1;
      end
      if ((p == 0) ? ack1_o : ack0_o) other_ack = 1'b1;
      if ((p == 0) ? ack0_o : ack1_o) begin
        got     = 1'b1;
        rd      = (p == 0) ? rdata0_o : rdata1_o;
        lat     = n + 1;  // cycles from the req-sampling cycle through the ack cycle
        resp_en = mem_enable_o;
      end
    end
    req0_i = 1'b0;
    req1_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: enable=%0b write=%0b, required 0 0", mem_enable_o, mem_write_o);
    end
    checks++;
    if (mem_addr_o !== '0) begin
      failures++; $display("FAIL reset_addr: got %h, required 0", mem_addr_o);
    end
    checks++;
    if (mem_data_o !== '0) begin
      failures++; $display("FAIL reset_data: got %h, required 0", mem_data_o);
    end
    checks++;
    if ({ack0_o, ack1_o} !== 2'b00) begin
      failures++; $display("FAIL reset_ack: got %b, required 00", {ack0_o, ack1_o});
    end
    checks++;
    if (rdata0_o !== '0 || rdata1_o !== '0) begin
      failures++; $display("FAIL reset_rdata: got %h / %h, required 0", rdata0_o, rdata1_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single_read();
    logic got, resp_en, other, bad; logic [DATA_W-1:0] rd; int lat, en;
    run_txn(0, 1'b0, 32'h40, '0, got, rd, lat, en, resp_en, other, bad);
    checks++;
    if (!got) begin failures++; $display("FAIL read_timeout: no ack0 within 40 cycles, required one"); end
    checks++;
    if (en != L_BUSY) begin failures++; $display("FAIL read_enable_len: got %0d, required %0d", en, L_BUSY); end
    checks++;
    if (bad) begin failures++; $display("FAIL read_cmd: mem_addr/write wrong while enabled, required 0x40 read"); end
    checks++;
    if (rd !== {32{8'hA5}}) begin failures++; $display("FAIL read_data: got %h, required a5..a5", rd); end
    checks++;
    if (lat != 2 + L_BUSY) begin failures++; $display("FAIL read_latency: got %0d, required %0d", lat, 2 + L_BUSY); end
    checks++;
    if (other || resp_en) begin
      failures++; $display("FAIL read_side: ack1 seen=%0b enable in RESP=%0b, required 0 0", other, resp_en);
    end
  endtask

  task automatic test_write_read();
    logic got, resp_en, other, bad; logic [DATA_W-1:0] rd; int lat, en;
    run_txn(1, 1'b1, 32'h20, 256'h1234, got, rd, lat, en, resp_en, other, bad);
    if (got) ref_store[32'h20] = 256'h1234;
    checks++;
    if (!got || bad || resp_en) begin
      failures++; $display("FAIL write_txn: ack=%0b bad_cmd=%0b enable in RESP=%0b, required 1 0 0", got, bad, resp_en);
    end
    checks++;
    if (rd !== '0) begin failures++; $display("FAIL write_rdata_hold: got %h, required 0", rd); end
    run_txn(1, 1'b0, 32'h20, '0, got, rd, lat, en, resp_en, other, bad);
    checks++;
    if (!got || rd !== 256'h1234) begin
      failures++; $display("FAIL readback: ack=%0b data=%h, required 1 and 1234", got, rd);
    end
    checks++;
    if (resp_en || other) begin
      failures++; $display("FAIL readback_side: enable in RESP=%0b ack0=%0b, required 0 0", resp_en, other);
    end
  endtask

  task automatic test_addr_hold();
    logic got, bad; int n, en;
    got = 1'b0; bad = 1'b0; n = 0; en = 0;
    @(negedge clk_i);
    req0_i = 1'b1; we0_i = 1'b0; addr0_i = 32'h40;
    while (!got && n < 40) begin
      @(negedge clk_i);
      n++;
      if (mem_enable_o) begin
        en++;
        if (mem_addr_o !== 32'h40) bad = 1'b1;
        if (en == 2) addr0_i = 32'h80;
      end
      if (ack0_o) got = 1'b1;
    end
    req0_i = 1'b0; addr0_i = '0;
    checks++;
    if (!got || en != L_BUSY) begin
      failures++; $display("FAIL hold_txn: ack=%0b enable cycles=%0d, required 1 %0d", got, en, L_BUSY);
    end
    checks++;
    if (bad) begin failures++; $display("FAIL hold_addr: mem_addr left 0x40 during BUSY, required 0x40"); end
  endtask

  task automatic test_reset_busy();
    logic got, resp_en, other, bad, ack_seen; logic [DATA_W-1:0] rd; int lat, en, n;
    n = 0; en = 0; ack_seen = 1'b0;
    @(negedge clk_i);
    req0_i = 1'b1; we0_i = 1'b0; addr0_i = 32'h60;
    while (en < 5 && n < 40) begin
      @(negedge clk_i);
      n++;
      if (mem_enable_o) en++;
    end
    checks++;
    if (en != 5) begin failures++; $display("FAIL rstbusy_reach: enable cycles %0d, required 5", en); end
    rst_i = 1'b1; req0_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (mem_enable_o !== 1'b0 || {ack0_o, ack1_o} !== 2'b00 || mem_addr_o !== '0) begin
      failures++;
      $display("FAIL rstbusy_state: enable=%0b acks=%b addr=%h, required 0 00 0", mem_enable_o, {ack0_o, ack1_o}, mem_addr_o);
    end
    rst_i = 1'b0;
    repeat (15) begin
      @(negedge clk_i);
      if (ack0_o || ack1_o) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen) begin failures++; $display("FAIL rstbusy_ack: ack after abandoned txn, required none"); end
    run_txn(0, 1'b0, 32'h60, '0, got, rd, lat, en, resp_en, other, bad);
    checks++;
    if (!got || rd !== ref_rd(32'h60) || lat != 2 + L_BUSY) begin
      failures++; $display("FAIL rstbusy_retry: ack=%0b lat=%0d data=%h, required 1 %0d %h", got, lat, rd, 2 + L_BUSY, ref_rd(32'h60));
    end
  endtask

  task automatic test_resp_arrival();
    logic got0, got, again0; logic [DATA_W-1:0] rd; int n, m, first_en;
    got0 = 1'b0; got = 1'b0; again0 = 1'b0; n = 0; m = 0; first_en = 0; rd = '0;
    @(negedge clk_i);
    req0_i = 1'b1; we0_i = 1'b0; addr0_i = 32'h40;
    while (!got0 && n < 40) begin
      @(negedge clk_i);
      n++;
      if (ack0_o) got0 = 1'b1;
    end
    req0_i = 1'b0;
    req1_i = 1'b1; we1_i = 1'b0; addr1_i = 32'h20;
    while (!got && m < 40) begin
      @(negedge clk_i);
      m++;
      if (mem_enable_o && first_en == 0) first_en = m;
      if (ack0_o) again0 = 1'b1;
      if (ack1_o) begin got = 1'b1; rd = rdata1_o; end
    end
    req1_i = 1'b0;
    checks++;
    if (!got0 || !got) begin failures++; $display("FAIL resp_arr_timeout: ack0=%0b ack1=%0b, required 1 1", got0, got); end
    checks++;
    if (first_en != 2) begin failures++; $display("FAIL resp_arr_grant: enable rose at %0d, required 2", first_en); end
    // Grant cycle is m=1, so ack1 lands 2+L cycles later counting the grant cycle.
    checks++;
    if (m != 2 + L_BUSY) begin failures++; $display("FAIL resp_arr_latency: got %0d, required %0d", m, 2 + L_BUSY); end
    checks++;
    if (rd !== 256'h1234 || again0) begin
      failures++; $display("FAIL resp_arr_data: data=%h extra ack0=%0b, required 1234 0", rd, again0);
    end
  endtask

  // Transaction-level model: the arbiter is free every 11 cycles at most; a grant at
  // cycle t gives enable in t+1..t+L and the ack in t+L+1.
  task automatic run_traffic(input int ncyc, input int prob);
    logic pend [2]; logic pwe [2];
    logic [ADDR_W-1:0] paddr [2]; logic [DATA_W-1:0] pwd [2]; logic [DATA_W-1:0] exp_rd [2];
    logic last_win, win, cur_we, exp_a0, exp_a1, exp_en;
    logic [ADDR_W-1:0] cur_addr; logic [DATA_W-1:0] cur_wd;
    int cur_p, grant_t, ack_t, free_at;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pwd[i] = '0; exp_rd[i] = '0;
    end
    last_win = 1'b1; win = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_wd = '0;
    cur_p = 0; grant_t = -100; ack_t = -1; free_at = 0;
    dut_log.delete();
    for (int t = 0; t < ncyc + 40; t++) begin
      @(negedge clk_i);
      if (ack0_o) dut_log.push_back(0);
      if (ack1_o) dut_log.push_back(1);
      exp_a0 = (t == ack_t) && (cur_p == 0);
      exp_a1 = (t == ack_t) && (cur_p == 1);
      exp_en = (t > grant_t) && (t < ack_t);
      checks++;
      if ({ack0_o, ack1_o} !== {exp_a0, exp_a1}) begin
        failures++; $display("FAIL traffic_ack t=%0d: got %b, required %b", t, {ack0_o, ack1_o}, {exp_a0, exp_a1});
      end
      checks++;
      if (mem_enable_o !== exp_en) begin
        failures++; $display("FAIL traffic_enable t=%0d: got %b, required %b", t, mem_enable_o, exp_en);
      end
      if (exp_en) begin
        checks++;
        if (mem_write_o !== cur_we || mem_addr_o !== cur_addr || (cur_we && mem_data_o !== cur_wd)) begin
          failures++;
          $display("FAIL traffic_cmd t=%0d: we=%b addr=%h, required we=%b addr=%h", t, mem_write_o, mem_addr_o, cur_we, cur_addr);
        end
      end
      if (t == ack_t) begin
        if (cur_we) ref_store[cur_addr] = cur_wd;
        else        exp_rd[cur_p] = ref_rd(cur_addr);
        pend[cur_p] = 1'b0;
      end
      checks++;
      if (rdata0_o !== exp_rd[0] || rdata1_o !== exp_rd[1]) begin
        failures++; $display("FAIL traffic_rdata t=%0d: got %h / %h, required %h / %h", t, rdata0_o, rdata1_o, exp_rd[0], exp_rd[1]);
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && !(t == ack_t && cur_p == p) && t < ncyc && $urandom_range(99) < prob) begin
          pend[p]  = 1'b1;
          pwe[p]   = 1'($urandom_range(1));
          paddr[p] = ADDR_W'($urandom_range(3)) << 5;
          pwd[p]   = {8{$urandom}};
        end
      end
      req0_i = pend[0]; we0_i = pwe[0]; addr0_i = paddr[0]; wdata0_i = pwd[0];
      req1_i = pend[1]; we1_i = pwe[1]; addr1_i = paddr[1]; wdata1_i = pwd[1];
      if (t > grant_t && t < ack_t) begin
        if (cur_p == 0) begin addr0_i = $urandom; wdata0_i = {8{$urandom}}; we0_i = ~cur_we; end
        else            begin addr1_i = $urandom; wdata1_i = {8{$urandom}}; we1_i = ~cur_we; end
      end
      if (t >= free_at && (pend[0] || pend[1])) begin
`ifdef DM_ARB_FIXED_PRIO_EN
        win = pend[1];
`else
        win = (pend[0] && pend[1]) ? ~last_win : pend[1];
`endif
        last_win = win;
        cur_p    = int'(win);
        cur_we   = pwe[win];
        cur_addr = paddr[win];
        cur_wd   = pwd[win];
        grant_t  = t;
        ack_t    = t + L_BUSY + 1;
        free_at  = ack_t + 1;
      end
    end
    req0_i = 1'b0; req1_i = 1'b0;
    checks++;
    if (pend[0] || pend[1]) begin
      failures++; $display("FAIL traffic_drain: pending %b%b at end, required 00", pend[1], pend[0]);
    end
  endtask

  task automatic test_round_robin();
    int exp_p;
    do_reset();
    run_traffic(44, 100);
    checks++;
    if (dut_log.size() < 4) begin
      failures++; $display("FAIL rr_count: %0d acks, required at least 4", dut_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef DM_ARB_FIXED_PRIO_EN
        exp_p = 1;
`else
        exp_p = i % 2;
`endif
        checks++;
        if (dut_log[i] != exp_p) begin
          failures++; $display("FAIL rr_order[%0d]: port %0d, required %0d", i, dut_log[i], exp_p);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    run_traffic(600, 35);
  endtask

  initial begin
    mem_store[32'h40] = {32{8'hA5}};
    ref_store[32'h40] = {32{8'hA5}};
    test_reset();
    test_single_read();
    test_write_read();
    test_addr_hold();
    test_reset_busy();
    test_resp_arrival();
    test_round_robin();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
